// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee vending datapath.
// The change dispenser uses the coin codes and its state enum from here.
package coffee_pkg;

   localparam int CUP_PRICE = 7;
   localparam int CHANGE_W  = 4;

   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_1    = 2'b01,
      COIN_2    = 2'b10,
      COIN_3    = 2'b11
   } coin_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SELECT = 2'b01,
      OFFER  = 2'b10,
      FAULT  = 2'b11
   } disp_state_t;

   function automatic logic [CHANGE_W-1:0] coin_value(input coin_t c);
      case (c)
         COIN_1:  coin_value = 4'd1;
         COIN_2:  coin_value = 4'd2;
         COIN_3:  coin_value = 4'd3;
         default: coin_value = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin pick: largest denomination that fits the owed amount and
// whose tube still has coins.
module coin_select
   import coffee_pkg::*;
(
   input  logic [CHANGE_W-1:0] remaining,
   input  logic [2:0]          hopper_empty,
   output coin_t               coin,
   output logic                found
);

   always_comb begin
      coin  = COIN_NONE;
      found = 1'b0;
      if (remaining >= 4'd3 && !hopper_empty[2]) begin
         coin  = COIN_3;
         found = 1'b1;
      end else if (remaining >= 4'd2 && !hopper_empty[1]) begin
         coin  = COIN_2;
         found = 1'b1;
      end else if (remaining >= 4'd1 && !hopper_empty[0]) begin
         coin  = COIN_1;
         found = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time through a ready/valid hopper port,
// with a one-deep queue for requests that arrive mid-payout.
module change_dispenser
   import coffee_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                dispense,
   input  logic [CHANGE_W-1:0] change,
   input  logic [2:0]          hopper_empty,
   input  logic                hopper_ready,
   output logic [1:0]          coin_out,
   output logic                coin_out_valid,
   output logic                busy,
   output logic                short_change,
   output logic [CHANGE_W-1:0] short_amount,
   output logic                overflow
);

   disp_state_t         state, state_n;
   logic [CHANGE_W-1:0] remaining, remaining_n;
   logic [CHANGE_W-1:0] pending, pending_n;
   logic                pend_vld, pend_vld_n;
   logic                ovf, ovf_n;
   coin_t               coin_q, coin_n, sel_coin;
   logic                sel_found;
   logic [CHANGE_W-1:0] left;

   coin_select u_sel (
      .remaining    (remaining),
      .hopper_empty (hopper_empty),
      .coin         (sel_coin),
      .found        (sel_found)
   );

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      pending_n   = pending;
      pend_vld_n  = pend_vld;
      coin_n      = coin_q;
      ovf_n       = ovf;
      left        = remaining - coin_value(coin_q);

      case (state)
         IDLE: begin
            if (dispense && change != '0) begin
               remaining_n = change;
               state_n     = SELECT;
            end
         end
         SELECT: begin
            if (sel_found) begin
               coin_n  = sel_coin;
               state_n = OFFER;
            end else begin
               state_n = FAULT;
            end
         end
         OFFER: begin
            if (hopper_ready) begin
               if (left != '0) begin
                  remaining_n = left;
                  state_n     = SELECT;
               end else if (pend_vld) begin
                  remaining_n = pending;
                  pend_vld_n  = 1'b0;
                  state_n     = SELECT;
               end else begin
                  remaining_n = '0;
                  state_n     = IDLE;
               end
            end
         end
         FAULT: begin
            if (sel_found) state_n = SELECT;
         end
         default: state_n = IDLE;
      endcase

      // Checked against pend_vld_n so an entry freed this cycle is reused.
      if (state != IDLE && dispense && change != '0) begin
         if (!pend_vld_n) begin
            pending_n  = change;
            pend_vld_n = 1'b1;
         end else begin
            ovf_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         pending   <= '0;
         pend_vld  <= 1'b0;
         coin_q    <= COIN_NONE;
         ovf       <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         pending   <= pending_n;
         pend_vld  <= pend_vld_n;
         coin_q    <= coin_n;
         ovf       <= ovf_n;
      end
   end

   assign coin_out_valid = (state == OFFER);
   assign coin_out       = coin_out_valid ? coin_q : COIN_NONE;
   assign short_change   = (state == FAULT);
   assign short_amount   = short_change ? remaining : '0;
   assign busy           = (state != IDLE) || pend_vld;
   assign overflow       = ovf;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have exactly these ports:
  clk  in  1  single system clock, rising-edge.
  reset  in  1  synchronous, active-high reset.
  dispense  in  1  one-cycle pulse from the vending FSM: a cup is being served.
  change  in  4  change owed, in rupees, valid when dispense=1.
  hopper_empty  in  3  bit0 = 1-rupee tube empty, bit1 = 2-rupee tube empty, bit2 = 3-rupee tube empty.
  hopper_ready  in  1  the hopper accepts the offered coin this cycle.
  coin_out  out  2  coin code offered: 01 = 1, 10 = 2, 11 = 3, 00 = none.
  coin_out_valid  out  1  coin_out is being offered.
  busy  out  1  a payout is in progress or queued.
  short_change  out  1  stalled because no usable coin is available.
  short_amount  out  4  rupees still owed while short_change=1, else 0.
  overflow  out  1  sticky flag: a request was dropped.

Function
REQ-002 The FSM SHALL have states IDLE, SELECT, OFFER and FAULT.
REQ-003 In IDLE, dispense=1 with change>0 SHALL load remaining=change and go to SELECT; change=0 SHALL be ignored.
REQ-004 SELECT SHALL choose the largest denomination d, taken from 3, 2 then 1, with d<=remaining and its tube not empty.
REQ-005 If a d exists, SELECT SHALL register coin_out=d and go to OFFER; otherwise it SHALL go to FAULT.
REQ-006 Latency SHALL be fixed: dispense sampled at edge N gives coin_out_valid=1 from cycle N+2.
REQ-007 In OFFER, coin_out_valid SHALL be 1 and coin_out SHALL hold stable until a cycle in which hopper_ready=1.
REQ-008 A transfer is coin_out_valid & hopper_ready. On a transfer, remaining SHALL become remaining-d.
REQ-009 After a transfer, the FSM SHALL go to SELECT if remaining>0; otherwise it SHALL complete (REQ-012).
REQ-010 In FAULT: short_change=1, short_amount=remaining, coin_out_valid=0.
REQ-011 FAULT SHALL return to SELECT in the first cycle any tube with denomination<=remaining is non-empty.
REQ-012 On completion, the FSM SHALL go to SELECT with the pending amount if pending is valid (pending cleared); otherwise it SHALL go to IDLE.
REQ-013 There SHALL be a one-entry pending buffer. dispense with change>0 while not in IDLE SHALL store change in pending if it is empty.
REQ-014 If pending is full, the request SHALL be dropped and overflow set to 1; overflow SHALL hold until reset.
REQ-015 A dispense in the same cycle pending is consumed (REQ-012) SHALL be stored into the freed pending entry, not dropped.
REQ-016 busy SHALL be 1 when state!=IDLE or pending is valid.
REQ-017 hopper_empty SHALL be sampled only in SELECT and FAULT; a change during OFFER SHALL NOT alter the offered coin.
REQ-018 remaining SHALL be 4 bits; subtraction SHALL never underflow, which is guaranteed by REQ-004.
REQ-019 coin_out SHALL be 00 whenever coin_out_valid=0.

Reset
REQ-020 When reset=1 at a rising edge, the block SHALL set state=IDLE, remaining=0, pending empty, and coin_out=00, coin_out_valid=0, busy=0, short_change=0, short_amount=0, overflow=0.
REQ-021 Reset mid-payout SHALL abandon the owed amount with no further coin offered; reset SHALL take priority over dispense in the same cycle.

Structure
REQ-022 Shared package coffee_pkg SHALL hold:
  - the coin-code enum (COIN_NONE, COIN_1, COIN_2, COIN_3);
  - the dispenser state enum;
  - the constant CUP_PRICE=7;
  - the change width constant (4).
REQ-023 The greedy denomination choice SHALL be a combinational sub-module coin_select with inputs remaining and hopper_empty, and outputs coin code and found.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - change=2, all tubes full, hopper_ready=1: one coin 10 offered at N+2, busy drops after transfer.
  - change=5, hopper_ready held 0 for 3 cycles then 1: coin 11 is held stable for 3 cycles, then coin 10 follows; total paid is 5.
  - change=3, 3-rupee tube empty: coins 10 then 01 are offered.
  - change=4, 3- and 1-rupee tubes empty:
      coin 10 is offered, then FAULT with short_amount=2 (2-rupee tube now empty).
      Refilling the 1-rupee tube gives two 01 coins.
  - Requests of 2, 1, 1 on back-to-back dispense pulses during a payout:
      the first and second are paid in order;
      the third is dropped and overflow=1.
  - Reset asserted during OFFER of change=6: all outputs are 0 the next cycle and no further coins are offered.
